// File: rtl/exu_wb_arbiter.sv
// exu_wb_arbiter
// Shares the single register-file write port between the five EXU result
// producers (0=LSU, 1=DIV, 2=MAC, 3=MUL, 4=ALU). The arbiter is round-robin
// with valid/ready handshakes. Write-back is registered, so a result granted
// in one cycle appears on exu_wb_* in the next. A saturating counter records
// every cycle in which two or more producers compete for the port.

module exu_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           req_valid,
    output logic [4:0]           req_ready,
    input  logic [24:0]          req_rd_addr,
    input  logic [5*XLEN-1:0]    req_data,
    input  logic [5*TAG_W-1:0]   req_tag,
    output logic [XLEN-1:0]      exu_wb_data,
    output logic [4:0]           exu_wb_rd_addr,
    output logic                 exu_wb_rd_wr_en,
    output logic [TAG_W-1:0]     exu_wb_tag,
    output logic                 wb_pending,
    output logic [CNT_W-1:0]     conflict_cnt,
    input  logic                 conflict_cnt_clr
);

    localparam int NSRC = 5;

    logic [2:0]       rr_ptr;
    logic [2:0]       start_ptr;
    logic [2:0]       grant_idx;
    logic             transfer;
    logic [2:0]       valid_cnt;
    logic [4:0]       rd_arr   [NSRC];
    logic [XLEN-1:0]  data_arr [NSRC];
    logic [TAG_W-1:0] tag_arr  [NSRC];

    // Split the packed per-source buses into arrays indexed by source number.
    for (genvar i = 0; i < NSRC; i++) begin : g_unpack
        assign rd_arr[i]   = req_rd_addr[5*i +: 5];
        assign data_arr[i] = req_data[XLEN*i +: XLEN];
        assign tag_arr[i]  = req_tag[TAG_W*i +: TAG_W];
    end

    // Moves to the next source index. After index 4 it wraps back to 0.
    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx == 3'd4) ? 3'd0 : idx + 3'd1;
    endfunction

    // Round-robin search that starts at rr_ptr and wraps 4->0. It uses only
    // req_valid and rr_ptr. Pointer values 5..7 cannot occur but are treated as 0.
    always_comb begin : arbitration
        logic [2:0] idx;
        start_ptr = (rr_ptr > 3'd4) ? 3'd0 : rr_ptr;
        req_ready = '0;
        grant_idx = '0;
        transfer  = 1'b0;
        idx       = start_ptr;
        for (int k = 0; k < NSRC; k++) begin
            if (!transfer && req_valid[idx]) begin
                req_ready[idx] = 1'b1;
                grant_idx      = idx;
                transfer       = 1'b1;
            end
            idx = next_idx(idx);
        end
    end

    // Counts the valid requests this cycle. Conflict detection uses this count.
    always_comb begin
        valid_cnt = '0;
        for (int k = 0; k < NSRC; k++) begin
            valid_cnt = valid_cnt + {2'b00, req_valid[k]};
        end
    end

    assign wb_pending = |(req_valid & ~req_ready);

    // Write-back register and pointer update. The enable is a one-cycle pulse.
    // A write to x0 is still accepted but does not enable the write. The
    // fields hold their values when no transfer occurs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exu_wb_data     <= '0;
            exu_wb_rd_addr  <= '0;
            exu_wb_rd_wr_en <= 1'b0;
            exu_wb_tag      <= '0;
            rr_ptr          <= '0;
        end else begin
            exu_wb_rd_wr_en <= transfer && (rd_arr[grant_idx] != 5'd0);
            if (transfer) begin
                exu_wb_data    <= data_arr[grant_idx];
                exu_wb_rd_addr <= rd_arr[grant_idx];
                exu_wb_tag     <= tag_arr[grant_idx];
                rr_ptr         <= next_idx(grant_idx);
            end
        end
    end

    // Saturating conflict counter. A clear takes priority over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (conflict_cnt_clr) begin
            conflict_cnt <= '0;
        end else if ((valid_cnt >= 3'd2) && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// tb_exu_wb_arbiter
// Scoreboard bench for the write-back arbiter. Each driven cycle pushes the
// expected write-back into a queue. The expected value comes from an
// independent round-robin model. The entry is popped and compared one cycle
// later.

module tb_exu_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int TAG_W = 8;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [7:0]  tag;
    } wb_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [4:0]          req_valid;
    logic [4:0]          req_ready;
    logic [24:0]         req_rd_addr;
    logic [5*XLEN-1:0]   req_data;
    logic [5*TAG_W-1:0]  req_tag;
    logic [XLEN-1:0]     exu_wb_data;
    logic [4:0]          exu_wb_rd_addr;
    logic                exu_wb_rd_wr_en;
    logic [TAG_W-1:0]    exu_wb_tag;
    logic                wb_pending;
    logic [CNT_W-1:0]    conflict_cnt;
    logic                conflict_cnt_clr;

    logic [4:0]          src_rd   [5];
    logic [31:0]         src_data [5];
    logic [7:0]          src_tag  [5];

    int                  checks = 0;
    int                  errors = 0;

    // Reference model state
    int                  m_ptr;
    wb_t                 m_hold;
    logic [15:0]         m_cnt;
    wb_t                 exp_q[$];
    logic [4:0]          exp_ready, obs_ready;
    logic                exp_pending, obs_pending;

    exu_wb_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_rd_addr      (req_rd_addr),
        .req_data         (req_data),
        .req_tag          (req_tag),
        .exu_wb_data      (exu_wb_data),
        .exu_wb_rd_addr   (exu_wb_rd_addr),
        .exu_wb_rd_wr_en  (exu_wb_rd_wr_en),
        .exu_wb_tag       (exu_wb_tag),
        .wb_pending       (wb_pending),
        .conflict_cnt     (conflict_cnt),
        .conflict_cnt_clr (conflict_cnt_clr)
    );

    always #5 clk = ~clk;

    for (genvar i = 0; i < 5; i++) begin : g_pack
        assign req_rd_addr[5*i +: 5]          = src_rd[i];
        assign req_data[XLEN*i +: XLEN]       = src_data[i];
        assign req_tag[TAG_W*i +: TAG_W]      = src_tag[i];
    end

    function automatic int pick(input int ptr, input logic [4:0] v);
        int p;
        p = (ptr > 4) ? 0 : ptr;
        for (int k = 0; k < 5; k++) begin
            if (v[(p + k) % 5]) return (p + k) % 5;
        end
        return -1;
    endfunction

    task automatic set_src(input int i, input logic [4:0] rd, input logic [31:0] d, input logic [7:0] t);
        src_rd[i]    = rd;
        src_data[i]  = d;
        src_tag[i]   = t;
        req_valid[i] = 1'b1;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_hold = '0;
        m_cnt  = '0;
        exp_q.delete();
    endtask

    // Inputs are already set just after a rising edge. This task samples the
    // combinational outputs at the falling edge, advances the model, pushes
    // the expected write-back, and returns 1 ns after the next rising edge.
    task automatic drive_cycle();
        int g;
        int pc;
        @(negedge clk);
        obs_ready   = req_ready;
        obs_pending = wb_pending;
        g = pick(m_ptr, req_valid);
        exp_ready = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            m_hold.rd    = src_rd[g];
            m_hold.data  = src_data[g];
            m_hold.tag   = src_tag[g];
            m_hold.en    = (src_rd[g] != 5'd0);
            m_ptr        = (g == 4) ? 0 : g + 1;
        end else begin
            m_hold.en = 1'b0;
        end
        exp_pending = |(req_valid & ~exp_ready);
        pc = 0;
        for (int k = 0; k < 5; k++) pc += int'(req_valid[k]);
        if (conflict_cnt_clr) m_cnt = '0;
        else if (pc >= 2 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        exp_q.push_back(m_hold);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        conflict_cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            src_rd[i] = '0; src_data[i] = '0; src_tag[i] = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({exu_wb_rd_wr_en, exu_wb_rd_addr, exu_wb_data, exu_wb_tag} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_wb got en=%b rd=%0d data=%h tag=%h exp all 0",
                     exu_wb_rd_wr_en, exu_wb_rd_addr, exu_wb_data, exu_wb_tag);
        end
        checks++;
        if (req_ready !== 5'b0 || wb_pending !== 1'b0 || conflict_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_misc got ready=%b pending=%b cnt=%0d exp 0/0/0",
                     req_ready, wb_pending, conflict_cnt);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        wb_t e;
        set_src(4, 5'd5, 32'hDEADBEEF, 8'h12);
        for (int c = 0; c < 2; c++) begin
            drive_cycle();
            checks++;
            if (obs_ready !== exp_ready || obs_ready !== ((c == 0) ? 5'b10000 : 5'b00000)) begin
                errors++;
                $display("[TB] FAIL single_ready c=%0d got %b exp %b", c, obs_ready, exp_ready);
            end
            e = exp_q.pop_front();
            checks++;
            if ({exu_wb_rd_wr_en, exu_wb_rd_addr, exu_wb_data, exu_wb_tag} !== e) begin
                errors++;
                $display("[TB] FAIL single_wb c=%0d got %b/%0d/%h/%h exp %b/%0d/%h/%h", c,
                         exu_wb_rd_wr_en, exu_wb_rd_addr, exu_wb_data, exu_wb_tag,
                         e.en, e.rd, e.data, e.tag);
            end
            req_valid[4] = 1'b0;
        end
    endtask

    task automatic test_full_contention();
        wb_t e;
        int order [6] = '{0, 1, 2, 3, 4, 0};
        logic [4:0] want;
        for (int i = 0; i < 5; i++) set_src(i, 5'(i + 1), 32'h1000_0000 * (i + 1), 8'(8'h40 + i));
        for (int c = 0; c < 6; c++) begin
            drive_cycle();
            want = 5'b00001 << order[c];
            checks++;
            if (obs_ready !== want || obs_ready !== exp_ready || obs_pending !== exp_pending) begin
                errors++;
                $display("[TB] FAIL contention_grant c=%0d got %b/%b exp %b/%b", c,
                         obs_ready, obs_pending, want, exp_pending);
            end
            e = exp_q.pop_front();
            checks++;
            if ({exu_wb_rd_wr_en, exu_wb_rd_addr, exu_wb_data, exu_wb_tag} !== e) begin
                errors++;
                $display("[TB] FAIL contention_wb c=%0d got rd=%0d data=%h exp rd=%0d data=%h", c,
                         exu_wb_rd_addr, exu_wb_data, e.rd, e.data);
            end
            checks++;
            if (conflict_cnt !== m_cnt) begin
                errors++;
                $display("[TB] FAIL contention_cnt c=%0d got %0d exp %0d", c, conflict_cnt, m_cnt);
            end
            if (c == 4) begin
                checks++;
                if (conflict_cnt !== 16'd5) begin
                    errors++;
                    $display("[TB] FAIL contention_cnt5 got %0d exp 5", conflict_cnt);
                end
            end
            if (c == 0) set_src(0, 5'd1, 32'hA0A0A0A0, 8'h4F);
            else req_valid[order[c]] = 1'b0;
        end
    endtask

    task automatic test_rr_wrap();
        wb_t e;
        logic [4:0] want [3] = '{5'b00100, 5'b01000, 5'b00001};
        set_src(2, 5'd7, 32'h0000_0222, 8'h22);
        for (int c = 0; c < 3; c++) begin
            drive_cycle();
            checks++;
            if (obs_ready !== want[c] || obs_ready !== exp_ready || obs_pending !== exp_pending) begin
                errors++;
                $display("[TB] FAIL rr_wrap_grant c=%0d got %b/%b exp %b/%b", c,
                         obs_ready, obs_pending, want[c], exp_pending);
            end
            e = exp_q.pop_front();
            checks++;
            if ({exu_wb_rd_wr_en, exu_wb_rd_addr, exu_wb_data, exu_wb_tag} !== e) begin
                errors++;
                $display("[TB] FAIL rr_wrap_wb c=%0d got rd=%0d data=%h exp rd=%0d data=%h", c,
                         exu_wb_rd_addr, exu_wb_data, e.rd, e.data);
            end
            if (c == 0) begin
                req_valid[2] = 1'b0;
                set_src(0, 5'd10, 32'h0000_0AAA, 8'h30);
                set_src(3, 5'd13, 32'h0000_0DDD, 8'h33);
            end else if (c == 1) begin
                req_valid[3] = 1'b0;
            end else begin
                req_valid[0] = 1'b0;
            end
        end
    endtask

    task automatic test_x0_write();
        wb_t e;
        logic [4:0] want [2] = '{5'b00010, 5'b00100};
        set_src(1, 5'd0, 32'h0000_0001, 8'h51);
        for (int c = 0; c < 2; c++) begin
            drive_cycle();
            checks++;
            if (obs_ready !== want[c] || obs_ready !== exp_ready) begin
                errors++;
                $display("[TB] FAIL x0_grant c=%0d got %b exp %b", c, obs_ready, want[c]);
            end
            e = exp_q.pop_front();
            checks++;
            if ({exu_wb_rd_wr_en, exu_wb_rd_addr, exu_wb_data, exu_wb_tag} !== e ||
                (c == 0 && exu_wb_rd_wr_en !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL x0_wb c=%0d got en=%b rd=%0d exp en=%b rd=%0d", c,
                         exu_wb_rd_wr_en, exu_wb_rd_addr, e.en, e.rd);
            end
            if (c == 0) begin
                set_src(1, 5'd9, 32'h0000_0099, 8'h52);
                set_src(2, 5'd8, 32'h0000_0088, 8'h53);
            end
        end
        req_valid = '0;
        drive_cycle();
        void'(exp_q.pop_front());
    endtask

    task automatic test_counter();
        for (int i = 0; i < 5; i++) set_src(i, 5'(i + 20), 32'hC000_0000 + i, 8'(8'h60 + i));
        for (int c = 0; c < (1 << CNT_W) + 3; c++) begin
            drive_cycle();
            void'(exp_q.pop_front());
        end
        checks++;
        if (conflict_cnt !== 16'hFFFF || m_cnt !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL cnt_saturate got %h exp ffff", conflict_cnt);
        end
        conflict_cnt_clr = 1'b1;
        drive_cycle();
        void'(exp_q.pop_front());
        conflict_cnt_clr = 1'b0;
        checks++;
        if (conflict_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL cnt_clear got %0d exp 0", conflict_cnt);
        end
        drive_cycle();
        void'(exp_q.pop_front());
        checks++;
        if (conflict_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL cnt_after_clear got %0d exp 1", conflict_cnt);
        end
        req_valid = '0;
        drive_cycle();
        void'(exp_q.pop_front());
    endtask

    task automatic test_async_reset();
        wb_t e;
        set_src(2, 5'd3, 32'h0000_3333, 8'h70);
        drive_cycle();
        void'(exp_q.pop_front());
        req_valid[2] = 1'b0;
        set_src(0, 5'd11, 32'h1111_0000, 8'h71);
        set_src(4, 5'd15, 32'h4444_0000, 8'h74);
        drive_cycle();
        checks++;
        if (obs_ready !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL areset_pre_grant got %b exp 10000", obs_ready);
        end
        e = exp_q.pop_front();
        checks++;
        if (exu_wb_rd_wr_en !== 1'b1 || exu_wb_rd_addr !== e.rd) begin
            errors++;
            $display("[TB] FAIL areset_inflight got en=%b rd=%0d exp en=1 rd=%0d",
                     exu_wb_rd_wr_en, exu_wb_rd_addr, e.rd);
        end
        #1;
        rst_n = 1'b0;
        req_valid[4] = 1'b0;
        #1;
        checks++;
        if (exu_wb_rd_wr_en !== 1'b0 || exu_wb_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL areset_drop got en=%b data=%h exp en=0 data=0",
                     exu_wb_rd_wr_en, exu_wb_data);
        end
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive_cycle();
            checks++;
            if (obs_ready !== exp_ready || obs_ready !== ((c == 0) ? 5'b00001 : 5'b00000)) begin
                errors++;
                $display("[TB] FAIL areset_regrant c=%0d got %b exp %b", c, obs_ready, exp_ready);
            end
            e = exp_q.pop_front();
            checks++;
            if ({exu_wb_rd_wr_en, exu_wb_rd_addr, exu_wb_data, exu_wb_tag} !== e) begin
                errors++;
                $display("[TB] FAIL areset_wb c=%0d got en=%b rd=%0d data=%h exp en=%b rd=%0d data=%h", c,
                         exu_wb_rd_wr_en, exu_wb_rd_addr, exu_wb_data, e.en, e.rd, e.data);
            end
            req_valid[0] = 1'b0;
        end
    endtask

    initial begin
        $display("[TB] starting exu_wb_arbiter bench");
        test_reset();
        test_single();
        test_full_contention();
        test_rr_wrap();
        test_x0_write();
        test_counter();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
